// File: rtl/pd_pkg.sv
// Shared types and constants for the power-domain result sequencer.
package pd_pkg;

   typedef enum logic [2:0] {
      ST_ON,
      ST_DRAIN,
      ST_SAVE,
      ST_ISO,
      ST_OFF,
      ST_PWRUP,
      ST_RESTORE,
      ST_UNISO
   } pd_state_e;

   localparam int SAVE_CYC_DEF  = 1;
   localparam int ISO_CYC_DEF   = 2;
   localparam int PWRUP_CYC_DEF = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // The dwell counter only ever holds (cycles - 1), so clog2 of the longest dwell is enough.
   function automatic int dwell_w(input int max_cyc);
      return (max_cyc > 1) ? $clog2(max_cyc) : 1;
   endfunction

   localparam int CNT_W = dwell_w(max3(SAVE_CYC_DEF, ISO_CYC_DEF, PWRUP_CYC_DEF));

endpackage

// File: rtl/pd_result_seq_if.sv
// Result bus between the switchable compute domain and the always-on holding registers.
// PD_RESULT_PARITY_EN adds the per-channel parity_err flags.
interface pd_result_seq_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 2
);
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] result;
   logic [NUM_CH-1:0]       result_valid;
`ifdef PD_RESULT_PARITY_EN
   logic [NUM_CH-1:0]       parity_err;

   modport master (output in_data, in_valid, input result, result_valid, parity_err);
   modport slave  (input in_data, in_valid, output result, result_valid, parity_err);
`else
   modport master (output in_data, in_valid, input result, result_valid);
   modport slave  (input in_data, in_valid, output result, result_valid);
`endif
endinterface

// File: rtl/pd_hold_reg.sv
// One always-on result channel: capture register, sticky valid flag, optional parity check.
// PD_RESULT_PARITY_EN adds the stored parity bit and parity_err output.
module pd_hold_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap_en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             q_valid
`ifdef PD_RESULT_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (cap_en) begin
         q       <= d;
         q_valid <= 1'b1;
      end
   end

`ifdef PD_RESULT_PARITY_EN
   logic par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par        <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (cap_en)
            par <= ^d;
         parity_err <= q_valid & ((^q) != par);
      end
   end
`endif

endmodule

// File: rtl/pd_result_seq.sv
// Power-down/up sequencer for one switchable compute domain plus its always-on result holding.
// PD_RESULT_PARITY_EN enables per-channel parity storage and parity_err on the bus.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ON      | domain powered and usable, results captured
//   DRAIN   | sleep requested, waiting for in-flight work to finish
//   SAVE    | retention save strobe for SAVE_CYC cycles
//   ISO     | clamps on, power still on, ISO_CYC cycles
//   OFF     | power removed, clamps on, waiting for wake_req
//   PWRUP   | power restored under isolation, PWRUP_CYC cycles
//   RESTORE | one-cycle retention restore strobe
//   UNISO   | clamps released, one cycle before ON
module pd_result_seq
   import pd_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_CH    = 2,
   parameter int SAVE_CYC  = SAVE_CYC_DEF,
   parameter int ISO_CYC   = ISO_CYC_DEF,
   parameter int PWRUP_CYC = PWRUP_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sleep_req,
   input  logic            wake_req,
   input  logic            pd_busy,
   output logic            pwr_en,
   output logic            iso_en,
   output logic            save,
   output logic            restore,
   output logic            awake,
   output logic            sleep_ack,
   pd_result_seq_if.slave  bus
);

   localparam int CW = dwell_w(max3(SAVE_CYC, ISO_CYC, PWRUP_CYC));

   pd_state_e state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ON;
         cnt       <= '0;
         pwr_en    <= 1'b1;
         iso_en    <= 1'b0;
         save      <= 1'b0;
         restore   <= 1'b0;
         awake     <= 1'b1;
         sleep_ack <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pwr_en    <= (state_nx != ST_OFF);
         iso_en    <= (state_nx == ST_ISO) || (state_nx == ST_OFF) ||
                      (state_nx == ST_PWRUP) || (state_nx == ST_RESTORE);
         save      <= (state_nx == ST_SAVE);
         restore   <= (state_nx == ST_RESTORE);
         awake     <= (state_nx == ST_ON);
         sleep_ack <= (state_nx == ST_OFF);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_ON:
            if (sleep_req)
               state_nx = ST_DRAIN;
         ST_DRAIN:
            if (!sleep_req) begin
               state_nx = ST_ON;
            end else if (!pd_busy) begin
               state_nx = ST_SAVE;
               cnt_nx   = CW'(SAVE_CYC - 1);
            end
         ST_SAVE:
            if (cnt == '0) begin
               state_nx = ST_ISO;
               cnt_nx   = CW'(ISO_CYC - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         ST_ISO:
            if (cnt == '0)
               state_nx = ST_OFF;
            else
               cnt_nx = cnt - 1'b1;
         ST_OFF:
            if (wake_req) begin
               state_nx = ST_PWRUP;
               cnt_nx   = CW'(PWRUP_CYC - 1);
            end
         ST_PWRUP:
            if (cnt == '0)
               state_nx = ST_RESTORE;
            else
               cnt_nx = cnt - 1'b1;
         ST_RESTORE:
            state_nx = ST_UNISO;
         ST_UNISO:
            state_nx = ST_ON;
         default:
            state_nx = ST_ON;
      endcase
   end

   // Capture only while ON so isolation clamps never reach the held results.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [WIDTH-1:0] q;
      logic             q_valid;

      pd_hold_reg #(.WIDTH(WIDTH)) u_hold (
         .clk        (clk),
         .rst_n      (rst_n),
         .cap_en     (bus.in_valid[c] && (state == ST_ON)),
         .d          (bus.in_data[c*WIDTH +: WIDTH]),
         .q          (q),
         .q_valid    (q_valid)
`ifdef PD_RESULT_PARITY_EN
         ,
         .parity_err (bus.parity_err[c])
`endif
      );

      assign bus.result[c*WIDTH +: WIDTH] = q;
      assign bus.result_valid[c]          = q_valid;

`ifndef SYNTHESIS
      a_in_known: assert property (@(posedge clk) disable iff (!rst_n)
         (bus.in_valid[c] && (state == ST_ON)) |-> !$isunknown(bus.in_data[c*WIDTH +: WIDTH]));
`endif
   end

endmodule

// File: doc/pd_result_seq.md
Name: pd_result_seq

Overview:
- Parametrised successor to the single-ALU result-propagation logic.
- Owns the power-down/power-up sequence for one switchable compute domain: pwr_en, iso_en, save and restore.
- Holds NUM_CH always-on result registers that capture only valid, un-isolated data.
- Sits in the always-on domain between the compute domain outputs and the visible result bus; held results survive domain power-off.

Parameters:
- WIDTH, 16, bits per channel result.
- NUM_CH, 2, number of result channels.
- SAVE_CYC, 1, cycles save is held high (must be >=1).
- ISO_CYC, 2, cycles iso_en is asserted before power is removed (must be >=1).
- PWRUP_CYC, 4, cycles after pwr_en rises before restore (must be >=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- sleep_req  in  1  level request to power the domain down
- wake_req  in  1  level request to power the domain up
- pd_busy  in  1  domain has an operation in flight
- in_data  in  NUM_CH*WIDTH  channel results from the domain; channel c is at [c*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  per-channel result strobe
- pwr_en  out  1  domain power switch enable
- iso_en  out  1  isolation clamp enable
- save  out  1  retention save strobe
- restore  out  1  retention restore strobe
- awake  out  1  domain usable; high only in ON
- sleep_ack  out  1  high only in OFF
- result  out  NUM_CH*WIDTH  held results
- result_valid  out  NUM_CH  per-channel sticky "holds captured data" flag

Behaviour:
- Reset: clk, with rst_n asynchronous and active-low.
  - Reset values: state=ON, pwr_en=1, iso_en=0, save=0, restore=0, awake=1, sleep_ack=0, result=0, result_valid=0.
  - Reset mid-sequence returns immediately to ON with the values above.
- FSM states, one shared dwell counter; all outputs registered:
  - ON: awake=1. Go to DRAIN when sleep_req=1.
  - DRAIN: wait until pd_busy=0, then go to SAVE. If sleep_req drops while in DRAIN, return to ON.
  - SAVE: save=1 for exactly SAVE_CYC cycles, then ISO.
  - ISO: iso_en=1 for ISO_CYC cycles with pwr_en still 1, then OFF.
  - OFF: pwr_en=0, iso_en=1, sleep_ack=1. Go to PWRUP when wake_req=1.
  - PWRUP: pwr_en=1, iso_en=1 for PWRUP_CYC cycles, then RESTORE.
  - RESTORE: restore=1 for exactly 1 cycle, then UNISO.
  - UNISO: iso_en=0 for 1 cycle, then ON.
- Request handling:
  - wake_req is ignored outside OFF. If it is held high during SAVE/ISO, the sequence completes to OFF and wakes the following cycle.
  - sleep_req is ignored outside ON/DRAIN.
  - sleep_req and wake_req both high in ON: sleep wins.
- Minimum sleep+wake round trip: 1+SAVE_CYC+ISO_CYC+1+PWRUP_CYC+1+1 cycles from sleep_req to awake.
- Capture rule: channel c updates on a clock edge iff in_valid[c]=1 and state==ON.
  - On capture, result[c] takes in_data[c] and result_valid[c] is set to 1.
  - Capture is blocked in all other states, so isolation clamps (zeros) are never captured.
  - Held values persist through OFF; power/isolation never clears them.
- Channels are independent; simultaneous valids on all channels capture in the same cycle.
- Registers update with no forwarding: result latency is 1 cycle from in_valid.
- Simulation-only assertion: in_data[c] has no X/Z when in_valid[c]=1 in ON.

Optional Feature:
- Macro: PD_RESULT_PARITY_EN.
- With the macro defined:
  - Adds output parity_err [NUM_CH].
  - Each channel stores an even-parity bit at capture.
  - parity_err[c] = result_valid[c] & (^result[c] != stored parity), registered, reset 0.
- Without the macro: the port, the parity storage and the logic are absent.

Decomposition:
- Shared package pd_pkg holds:
  - state enum: ON, DRAIN, SAVE, ISO, OFF, PWRUP, RESTORE, UNISO.
  - counter width constant (clog2 of the max dwell).
  - default dwell constants.
- One natural sub-module, pd_hold_reg: a single-channel WIDTH-bit capture register with valid flag and optional parity. It is instantiated NUM_CH times by generate.

Test Plan:
- Reset then in_valid=2'b01 with ch0 data 16'hA5A5 in ON -> result ch0=A5A5 one cycle later, result_valid=01, ch1=0.
- sleep_req=1 with pd_busy=1 for 3 cycles -> FSM stays in DRAIN 3 cycles, then save high 1 cycle, iso_en high 2 cycles before pwr_en=0, sleep_ack=1.
- In OFF, in_valid=11 with in_data=0 -> no capture; ch0 still A5A5.
- wake_req=1 in OFF -> pwr_en=1 with iso_en=1 for 4 cycles, restore pulse 1 cycle, iso_en=0, awake=1 on the 7th cycle after wake.
- wake_req held high from SAVE onward -> OFF lasts exactly 1 cycle, then PWRUP.
- rst_n low during PWRUP -> immediately pwr_en=1, iso_en=0, result=0, result_valid=0.
